seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Sequential radix-2 shift-add multiplier for 32-bit signed (two's complement) operands; produces a 64-bit signed product.
- Inverse-operation companion to the team's sequential non-restoring divider, and uses the same arithmetic style: magnitude conversion, iterative core, sign fixup.
- Sits beside the divider in the datapath; started by a one-cycle request and reports completion with a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand, two's complement
- b  input  WIDTH  multiplier, two's complement
- busy  output  1  high while an operation is in progress (CALC, FIX)
- done  output  1  one-cycle pulse when p becomes valid
- p  output  2*WIDTH  signed product; holds last result until next accepted start

Behaviour:
- Reset, synchronous, on a clk edge with rst=1: state=IDLE, busy=0, done=0, p=0, internal accumulator/counter cleared. Takes priority over every other input, including mid-operation; the in-flight result is discarded.
- State IDLE:
  - done=0 except on the pulse cycle.
  - On an edge with start=1: latch ma=|a| and mb=|b| as WIDTH-bit unsigned magnitudes, and latch neg=a[W-1]^b[W-1].
  - Magnitude of the most negative value 2^(W-1) is represented exactly as unsigned.
  - Clear the 2*WIDTH-bit accumulator, load counter=WIDTH, go to CALC. busy=1 from the next cycle.
- State CALC, one iteration per edge:
  - If mb[0]: acc = acc + (ma << (WIDTH-counter)). Equivalent shift-right accumulator form is acceptable if results are identical.
  - mb shifts right; counter decrements.
  - On the edge where counter reaches 0, go to FIX. CALC lasts exactly WIDTH edges.
- State FIX, one edge:
  - p = neg ? (~acc + 1) : acc.
  - done=1 for exactly one cycle, busy=0, go to IDLE.
- Latency: start accepted at edge N; p valid and done=1 after edge N+WIDTH+1 (33 edges for WIDTH=32).
- start while busy is ignored; no queuing, no effect on the current operation.
- start asserted in the same cycle done is high is accepted, since the state is IDLE; done stays a single-cycle pulse.
- a and b are sampled only at acceptance; later changes have no effect.
- Zero operand: the full latency still applies; p=0, never negative zero.
- Width rules:
  - Accumulator is 2*WIDTH bits unsigned with no overflow possible.
  - Max magnitude product 2^(2W-2) (from -2^(W-1) * -2^(W-1)) fits the signed 2*WIDTH-bit result.

Test Plan:
- a=7, b=6, start pulse -> busy high 33 cycles, done pulse once, p=0x000000000000002A.
- a=-3 (0xFFFFFFFD), b=5 -> p=0xFFFFFFFFFFFFFFF1 (-15). Repeat with a=-3, b=-5 -> p=0x000000000000000F.
- a=0x80000000, b=0x80000000 -> p=0x4000000000000000. a=0x80000000, b=1 -> p=0xFFFFFFFF80000000.
- a=0x7FFFFFFF, b=0 -> done at the same latency, p=0. Then start pulsed at cycle 5 of a second operation -> ignored, p matches the first operand pair only.
- rst=1 at CALC cycle 10 -> next cycle busy=0, done=0, p=0, no done pulse follows. New start a=2, b=3 -> p=6 after 33 edges.
- Back-to-back: start held high continuously with alternating operands -> each result correct, done pulses every 34 cycles, p stable between pulses.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add signed multiplier: magnitude conversion, WIDTH-step
// add/shift core, then a sign fixup cycle. One-cycle start request, one-cycle done pulse.
module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]     p_q, p_d;
  logic [WIDTH-1:0]  mb_q, mb_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  mag_a, mag_b;

  // Unsigned magnitudes; the most negative value maps exactly to 2^(WIDTH-1).
  always_comb begin
    mag_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    mag_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    mb_d    = mb_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = {{WIDTH{1'b0}}, mag_a};
          mb_d    = mag_b;
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
          acc_d   = '0;
          cnt_d   = CntW'(WIDTH);
          state_d = StCalc;
        end
      end
      StCalc: begin
        // Shifted multiplicand is added for each set multiplier bit, LSB first.
        if (mb_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mb_d    = mb_q >> 1;
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        p_d     = neg_q ? (~acc_q + PW'(1)) : acc_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      mcand_q <= '0;
      p_q     <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      mb_q    <= mb_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == StCalc) || (state_q == StFix);
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed corner cases, randomized operands, reset abort and
// back-to-back operation, all checked against a plain signed-multiply reference.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] p;

  int n_checks = 0;
  int n_fail   = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return sx * sy;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One operation from IDLE; optionally pulses a stray start at CALC cycle inject_at.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input int inject_at,
                       input string tag);
    logic [63:0] exp;
    int k, busy_cnt;
    exp = ref_mul(x, y);
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    k = 0; busy_cnt = 0;
    while (!done && k < 100) begin
      if (busy) busy_cnt++;
      if (k == inject_at) begin
        start = 1'b1; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(k), 64'd33);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " p"}, p, exp);
    @(negedge clk);
    check({tag, " done_single"}, 64'(done), 64'd0);
    check({tag, " p_hold"}, p, exp);
  endtask

  initial begin
    logic [31:0] xa [2];
    logic [31:0] yb [2];
    logic [63:0] cur;
    logic [31:0] corner [6];
    int k, last_done, n_done, idx, done_seen;
    bit have;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset p", p, 64'd0);
    rst = 1'b0;

    do_op(32'd7, 32'd6, -1, "7x6");
    check("7x6 const", p, 64'h0000_0000_0000_002A);
    do_op(32'hFFFF_FFFD, 32'd5, -1, "m3x5");
    check("m3x5 const", p, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op(32'hFFFF_FFFD, 32'hFFFF_FFFB, -1, "m3xm5");
    check("m3xm5 const", p, 64'h0000_0000_0000_000F);
    do_op(32'h8000_0000, 32'h8000_0000, -1, "minxmin");
    check("minxmin const", p, 64'h4000_0000_0000_0000);
    do_op(32'h8000_0000, 32'd1, -1, "minx1");
    check("minx1 const", p, 64'hFFFF_FFFF_8000_0000);
    do_op(32'h7FFF_FFFF, 32'd0, -1, "maxx0");
    do_op(32'hFFFF_FFFF, 32'd0, -1, "neg_zero");
    check("neg_zero const", p, 64'd0);
    do_op(32'd12345, 32'hFFFF_F00D, 5, "stray_start");

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    start = 1'b1; a = 32'd1000; b = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort p", p, 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort no_done", 64'(done_seen), 64'd0);
    do_op(32'd2, 32'd3, -1, "after_abort");
    check("after_abort const", p, 64'd6);

    corner[0] = 32'h8000_0000; corner[1] = 32'h7FFF_FFFF; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'd0;         corner[4] = 32'd1;         corner[5] = 32'h0001_0000;
    for (int i = 0; i < 12; i++) begin
      logic [31:0] x, y;
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      do_op(x, y, -1, $sformatf("rand%0d", i));
    end

    // Back-to-back: start held high, operands switched on each done cycle.
    xa[0] = $urandom; yb[0] = $urandom; xa[1] = $urandom; yb[1] = $urandom;
    @(negedge clk);
    start = 1'b1; a = xa[0]; b = yb[0];
    idx = 0; k = 0; last_done = 0; n_done = 0; have = 1'b0; cur = '0;
    while (n_done < 4 && k < 400) begin
      @(negedge clk);
      k++;
      if (done) begin
        check($sformatf("b2b p%0d", n_done), p, ref_mul(xa[idx], yb[idx]));
        if (n_done > 0) check($sformatf("b2b period%0d", n_done), 64'(k - last_done), 64'd34);
        last_done = k;
        n_done++;
        cur = ref_mul(xa[idx], yb[idx]);
        have = 1'b1;
        idx ^= 1;
        a = xa[idx]; b = yb[idx];
        if (n_done == 4) start = 1'b0;
      end else if (have) begin
        check("b2b p_stable", p, cur);
      end
    end
    start = 1'b0;
    check("b2b count", 64'(n_done), 64'd4);
    repeat (3) @(negedge clk);
    check("b2b idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
